// File: rtl/fft_agu.sv
// Address generator for an in-place radix-2, 64-point FFT: issues one butterfly per cycle
// and replays each issue's addresses PIPE_LAT cycles later as the matching write.
module fft_agu #(
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [5:0] read_adr_a,
    output logic [5:0] read_adr_b,
    output logic [4:0] twiddle_address,
    output logic       read_bank,
    output logic       write,
    output logic [5:0] write_adr_a,
    output logic [5:0] write_adr_b,
    output logic       write_bank,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(PIPE_LAT - 1);
    localparam logic [2:0] LEVEL_LAST = 3'd5;

    state_t     state_q;
    logic [2:0] level_q;
    logic [4:0] j_q;
    logic [2:0] drain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= 3'd0;
            j_q     <= 5'd0;
            drain_q <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        level_q <= 3'd0;
                        j_q     <= 5'd0;
                    end
                end
                RUN: begin
                    j_q <= j_q + 5'd1;
                    if (j_q == 5'd31) begin
                        state_q <= DRAIN;
                        drain_q <= 3'd0;
                    end
                end
                DRAIN: begin
                    // Holding here until the pipeline empties keeps the next level's
                    // first read strictly after this level's last write.
                    if (drain_q == DRAIN_LAST) begin
                        drain_q <= 3'd0;
                        if (level_q == LEVEL_LAST) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                            level_q <= level_q + 3'd1;
                            j_q     <= 5'd0;
                        end
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    level_q <= 3'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic       run;
    logic [5:0] base_a;
    logic [5:0] base_b;

    assign run    = (state_q == RUN);
    assign base_a = {j_q, 1'b0};
    assign base_b = {j_q, 1'b1};

    always_comb begin
        read_adr_a      = 6'd0;
        read_adr_b      = 6'd0;
        twiddle_address = 5'd0;
        read_bank       = 1'b0;
        if (run) begin
            read_adr_a      = (base_a << level_q) | (base_a >> (3'd6 - level_q));
            read_adr_b      = (base_b << level_q) | (base_b >> (3'd6 - level_q));
            twiddle_address = j_q & ~(5'b11111 >> level_q);
            read_bank       = level_q[0];
        end
    end

    logic [PIPE_LAT-1:0] vld_q;
    logic [PIPE_LAT-1:0] pbank_q;
    logic [5:0]          pa_q [PIPE_LAT];
    logic [5:0]          pb_q [PIPE_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= '0;
            pbank_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pa_q[i] <= 6'd0;
                pb_q[i] <= 6'd0;
            end
        end else begin
            vld_q   <= {vld_q[PIPE_LAT-2:0], run};
            pbank_q <= {pbank_q[PIPE_LAT-2:0], ~read_bank};
            pa_q[0] <= read_adr_a;
            pb_q[0] <= read_adr_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pa_q[i] <= pa_q[i-1];
                pb_q[i] <= pb_q[i-1];
            end
        end
    end

    assign write       = vld_q[PIPE_LAT-1];
    assign write_adr_a = write ? pa_q[PIPE_LAT-1] : 6'd0;
    assign write_adr_b = write ? pb_q[PIPE_LAT-1] : 6'd0;
    assign write_bank  = write & pbank_q[PIPE_LAT-1];

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule
